apb_splitter: RTL and testbench
===============================

APB_SPLITTER -- requirements
Module: apb_splitter

Interface
REQ-001 SHALL have parameter AW_APB, default 32, address width.
REQ-002 SHALL have parameter DW_APB, default 32, data width (multiple of 8); strobe width DW_APB/8.
REQ-003 SHALL have parameter N_SLV, default 4, downstream slave count (1..16).
REQ-004 SHALL have parameter SLV_BASE, N_SLV*AW_APB bits, default slot i base = i*0x1000.
REQ-005 SHALL have parameter SLV_MASK, N_SLV*AW_APB bits, default all slots 0xFFFF_F000.
REQ-006 SHALL have parameter TIMEOUT_CYC, default 16, access-phase wait limit; 0 disables the timeout.
REQ-007 SHALL have port clk  in  1  sole clock, rising edge.
REQ-008 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-009 SHALL have ports s_paddr/s_psel/s_penable/s_pwrite/s_pwdata/s_pprot[3]/s_pstrb  in  upstream APB request.
REQ-010 SHALL have ports s_pready/s_prdata/s_pslverr  out  upstream APB response.
REQ-011 SHALL have ports m_paddr/m_pwrite/m_pwdata/m_pprot/m_pstrb/m_penable  out  shared downstream request, plus m_psel  out  N_SLV  one-hot select.
REQ-012 SHALL have ports m_pready  in  N_SLV, m_pslverr  in  N_SLV, m_prdata  in  N_SLV*DW_APB  per-slave response.

Function
REQ-013 SHALL decode slot i as hit when (s_paddr & MASK_i) == (BASE_i & MASK_i); lowest matching index wins on overlap.
REQ-014 SHALL implement FSM IDLE, SETUP, ACCESS, RESP, ERR.
REQ-015 IDLE: on s_psel=1 & s_penable=0, capture addr/write/wdata/prot/strb; hit -> SETUP, miss -> ERR.
REQ-016 SETUP (1 cycle): m_psel[hit]=1, m_penable=0, m_* carry captured values -> ACCESS.
REQ-017 ACCESS: m_psel[hit]=1, m_penable=1; on m_pready[hit]=1 capture m_prdata[hit] and m_pslverr[hit] -> RESP.
REQ-018 ACCESS timeout: counter cleared on entry, increments each cycle with m_pready[hit]=0; on reaching TIMEOUT_CYC -> RESP with prdata=0, pslverr=1.
REQ-019 RESP (1 cycle): s_pready=1, s_prdata/s_pslverr = captured values, all m_psel=0, m_penable=0 -> IDLE.
REQ-020 ERR (1 cycle): s_pready=1, s_pslverr=1, s_prdata=0; no m_psel asserted -> IDLE.
REQ-021 Zero-wait slave latency: upstream setup in cycle 0, s_pready=1 in cycle 3; each downstream wait cycle adds one.
REQ-022 s_pready SHALL be 0 in all states except RESP and ERR; s_prdata SHALL be 0 whenever s_pready=0.
REQ-023 Writes SHALL report prdata=0 regardless of m_prdata.
REQ-024 Upstream inputs SHALL be ignored outside IDLE; an in-flight transfer always completes even if s_psel drops.
REQ-025 m_psel SHALL never have more than one bit set.

Reset
REQ-026 On rst=1, asynchronously: FSM=IDLE, counter=0, all outputs (s_pready, s_prdata, s_pslverr, m_psel, m_penable, m_paddr, m_pwdata, m_pwrite, m_pprot, m_pstrb) = 0.
REQ-027 Reset mid-transfer SHALL abort it; no s_pready pulse after reset release until a new setup phase.

Structure
REQ-028 Shared package apb_pkg SHALL hold the FSM state enum and the PROT/STRB width constants.
REQ-029 Address decode SHALL be a sub-module apb_addr_decoder (combinational, outputs hit flag and index).
REQ-030 All outputs SHALL be driven from registers.

Verification
REQ-031 Write 0x0000_1004 data 0xDEADBEEF, slave1 zero-wait -> m_psel=0b0010 cycles 1-2, m_penable cycle 2, s_pready cycle 3, pslverr=0.
REQ-032 Read 0x0000_3010, slave3 returns 0x12345678 after 3 wait cycles -> s_pready cycle 6, s_prdata=0x12345678.
REQ-033 Read 0x0001_0000 (no hit) -> m_psel=0 throughout, s_pready=1 and s_pslverr=1 in cycle 1, s_prdata=0.
REQ-034 Read 0x0000_2000, slave2 never ready, TIMEOUT_CYC=16 -> s_pready=1 with s_pslverr=1, s_prdata=0, m_psel dropped same cycle.
REQ-035 Overlapping windows slot0 mask 0, access 0x0000_1000 -> slot0 selected.
REQ-036 rst pulsed during ACCESS -> m_psel/m_penable=0 immediately, no s_pready after release, next transfer completes normally.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB splitter and its address decoder.
package apb_pkg;

    // Transfer sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_RESP   = 3'd3,
        ST_ERR    = 3'd4
    } apb_state_e;

    localparam int PROT_W        = 3;
    localparam int STRB_LANE_W   = 8;    // one strobe bit covers one byte lane
    localparam int MAX_SLV       = 16;
    localparam int MAX_PACK_W    = 1024; // widest packed base/mask table supported

    function automatic int strb_w(input int dw);
        return dw / STRB_LANE_W;
    endfunction

    // Width of a slave index; a single slave still gets one bit
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Default base table: slot i sits at i*0x1000
    function automatic logic [MAX_PACK_W-1:0] def_base(input int n, input int aw);
        logic [MAX_PACK_W-1:0] r;
        r = '0;
        for (int i = 0; i < n; i++) begin
            r = r | (MAX_PACK_W'(i * 4096) << (i * aw));
        end
        return r;
    endfunction

    // Default mask table: every slot decodes a 4 KiB window
    function automatic logic [MAX_PACK_W-1:0] def_mask(input int n, input int aw);
        logic [MAX_PACK_W-1:0] r;
        logic [MAX_PACK_W-1:0] m;
        r = '0;
        m = ((MAX_PACK_W'(1) << aw) - MAX_PACK_W'(1)) & ~MAX_PACK_W'(4095);
        for (int i = 0; i < n; i++) begin
            r = r | (m << (i * aw));
        end
        return r;
    endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational base/mask address decoder; lowest-numbered matching slot wins.
module apb_addr_decoder
    import apb_pkg::*;
#(
    parameter int                      AW    = 32,
    parameter int                      N_SLV = 4,
    parameter logic [N_SLV*AW-1:0]     BASE  = '0,
    parameter logic [N_SLV*AW-1:0]     MASK  = '0,
    parameter int                      IW    = idx_w(N_SLV)
) (
    input  logic [AW-1:0] addr_i,
    output logic          hit_o,
    output logic [IW-1:0] idx_o
);

    // Scan from the top slot down so the lowest match is written last
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        for (int i = N_SLV - 1; i >= 0; i--) begin
            if ((addr_i & MASK[i*AW +: AW]) == (BASE[i*AW +: AW] & MASK[i*AW +: AW])) begin
                hit_o = 1'b1;
                idx_o = IW'(i);
            end
        end
    end

endmodule

// File: rtl/apb_splitter.sv
// One-to-N APB splitter: decodes the upstream address, runs a single
// downstream transfer to the selected slave, and returns its response.
// Every output comes straight from a register.
module apb_splitter
    import apb_pkg::*;
#(
    parameter int                          AW_APB      = 32,
    parameter int                          DW_APB      = 32,
    parameter int                          N_SLV       = 4,
    parameter logic [N_SLV*AW_APB-1:0]     SLV_BASE    = (N_SLV*AW_APB)'(def_base(N_SLV, AW_APB)),
    parameter logic [N_SLV*AW_APB-1:0]     SLV_MASK    = (N_SLV*AW_APB)'(def_mask(N_SLV, AW_APB)),
    parameter int                          TIMEOUT_CYC = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    // upstream request
    input  logic [AW_APB-1:0]         s_paddr,
    input  logic                      s_psel,
    input  logic                      s_penable,
    input  logic                      s_pwrite,
    input  logic [DW_APB-1:0]         s_pwdata,
    input  logic [PROT_W-1:0]         s_pprot,
    input  logic [DW_APB/8-1:0]       s_pstrb,
    // upstream response
    output logic                      s_pready,
    output logic [DW_APB-1:0]         s_prdata,
    output logic                      s_pslverr,
    // shared downstream request
    output logic [AW_APB-1:0]         m_paddr,
    output logic                      m_pwrite,
    output logic [DW_APB-1:0]         m_pwdata,
    output logic [PROT_W-1:0]         m_pprot,
    output logic [DW_APB/8-1:0]       m_pstrb,
    output logic                      m_penable,
    output logic [N_SLV-1:0]          m_psel,
    // per-slave response
    input  logic [N_SLV-1:0]          m_pready,
    input  logic [N_SLV-1:0]          m_pslverr,
    input  logic [N_SLV*DW_APB-1:0]   m_prdata
);

    localparam int IW = idx_w(N_SLV);
    localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    // Timeout fires on the last waited cycle, so ACCESS lasts at most TIMEOUT_CYC cycles
    localparam logic [CW-1:0] TO_LAST = (TIMEOUT_CYC > 0) ? CW'(TIMEOUT_CYC - 1) : '0;

    apb_state_e               state_q, state_d;
    logic [IW-1:0]            idx_q, idx_d;
    logic [CW-1:0]            cnt_q, cnt_d;

    logic                     s_pready_q, s_pready_d;
    logic [DW_APB-1:0]        s_prdata_q, s_prdata_d;
    logic                     s_pslverr_q, s_pslverr_d;
    logic [AW_APB-1:0]        m_paddr_q, m_paddr_d;
    logic                     m_pwrite_q, m_pwrite_d;
    logic [DW_APB-1:0]        m_pwdata_q, m_pwdata_d;
    logic [PROT_W-1:0]        m_pprot_q, m_pprot_d;
    logic [DW_APB/8-1:0]      m_pstrb_q, m_pstrb_d;
    logic                     m_penable_q, m_penable_d;
    logic [N_SLV-1:0]         m_psel_q, m_psel_d;

    logic                     dec_hit;
    logic [IW-1:0]            dec_idx;
    logic [N_SLV-1:0][DW_APB-1:0] rdata_arr;

    assign rdata_arr = m_prdata;

    apb_addr_decoder #(
        .AW    (AW_APB),
        .N_SLV (N_SLV),
        .BASE  (SLV_BASE),
        .MASK  (SLV_MASK),
        .IW    (IW)
    ) u_dec (
        .addr_i (s_paddr),
        .hit_o  (dec_hit),
        .idx_o  (dec_idx)
    );

    // Next state, and next values of every output register
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        m_paddr_d   = m_paddr_q;
        m_pwrite_d  = m_pwrite_q;
        m_pwdata_d  = m_pwdata_q;
        m_pprot_d   = m_pprot_q;
        m_pstrb_d   = m_pstrb_q;
        // response is a one-cycle pulse; data stays zero when not ready
        s_pready_d  = 1'b0;
        s_prdata_d  = '0;
        s_pslverr_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (s_psel && !s_penable) begin
                    m_paddr_d  = s_paddr;
                    m_pwrite_d = s_pwrite;
                    m_pwdata_d = s_pwdata;
                    m_pprot_d  = s_pprot;
                    m_pstrb_d  = s_pstrb;
                    idx_d      = dec_idx;
                    if (dec_hit) begin
                        state_d = ST_SETUP;
                    end else begin
                        state_d     = ST_ERR;
                        s_pready_d  = 1'b1;
                        s_pslverr_d = 1'b1;
                    end
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
                cnt_d   = '0;
            end
            ST_ACCESS: begin
                if (m_pready[idx_q]) begin
                    state_d     = ST_RESP;
                    s_pready_d  = 1'b1;
                    s_pslverr_d = m_pslverr[idx_q];
                    s_prdata_d  = m_pwrite_q ? '0 : rdata_arr[idx_q];
                end else if (TIMEOUT_CYC != 0 && cnt_q == TO_LAST) begin
                    state_d     = ST_RESP;
                    s_pready_d  = 1'b1;
                    s_pslverr_d = 1'b1;
                end else if (TIMEOUT_CYC != 0) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RESP, ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // select follows the state we are entering, so it is registered in step
        m_psel_d = '0;
        if (state_d == ST_SETUP || state_d == ST_ACCESS) begin
            m_psel_d[idx_d] = 1'b1;
        end
        m_penable_d = (state_d == ST_ACCESS);
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            s_pready_q  <= 1'b0;
            s_prdata_q  <= '0;
            s_pslverr_q <= 1'b0;
            m_paddr_q   <= '0;
            m_pwrite_q  <= 1'b0;
            m_pwdata_q  <= '0;
            m_pprot_q   <= '0;
            m_pstrb_q   <= '0;
            m_penable_q <= 1'b0;
            m_psel_q    <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            s_pready_q  <= s_pready_d;
            s_prdata_q  <= s_prdata_d;
            s_pslverr_q <= s_pslverr_d;
            m_paddr_q   <= m_paddr_d;
            m_pwrite_q  <= m_pwrite_d;
            m_pwdata_q  <= m_pwdata_d;
            m_pprot_q   <= m_pprot_d;
            m_pstrb_q   <= m_pstrb_d;
            m_penable_q <= m_penable_d;
            m_psel_q    <= m_psel_d;
        end
    end

    assign s_pready  = s_pready_q;
    assign s_prdata  = s_prdata_q;
    assign s_pslverr = s_pslverr_q;
    assign m_paddr   = m_paddr_q;
    assign m_pwrite  = m_pwrite_q;
    assign m_pwdata  = m_pwdata_q;
    assign m_pprot   = m_pprot_q;
    assign m_pstrb   = m_pstrb_q;
    assign m_penable = m_penable_q;
    assign m_psel    = m_psel_q;

endmodule

// File: tb/tb_apb_splitter.sv
// Directed scoreboard bench for apb_splitter: expected responses are queued
// at issue time and checked by a monitor whenever s_pready is seen.
module tb_apb_splitter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic [N*AW-1:0] OVL_MASK = {32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000, 32'h0000_0000};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [AW-1:0]   s_paddr;
    logic            s_psel, s_penable, s_pwrite;
    logic [DW-1:0]   s_pwdata;
    logic [2:0]      s_pprot;
    logic [DW/8-1:0] s_pstrb;
    logic            s_pready, s_pslverr;
    logic [DW-1:0]   s_prdata;
    logic [AW-1:0]   m_paddr;
    logic            m_pwrite, m_penable;
    logic [DW-1:0]   m_pwdata;
    logic [2:0]      m_pprot;
    logic [DW/8-1:0] m_pstrb;
    logic [N-1:0]    m_psel, m_pready, m_pslverr;
    logic [N*DW-1:0] m_prdata;

    // second instance: slot0 mask 0 overlaps every window
    logic            s2_pready, s2_pslverr;
    logic [DW-1:0]   s2_prdata;
    logic [AW-1:0]   m2_paddr;
    logic            m2_pwrite, m2_penable;
    logic [DW-1:0]   m2_pwdata;
    logic [2:0]      m2_pprot;
    logic [DW/8-1:0] m2_pstrb;
    logic [N-1:0]    m2_psel;

    apb_splitter dut (
        .clk(clk), .rst(rst),
        .s_paddr(s_paddr), .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
        .s_pwdata(s_pwdata), .s_pprot(s_pprot), .s_pstrb(s_pstrb),
        .s_pready(s_pready), .s_prdata(s_prdata), .s_pslverr(s_pslverr),
        .m_paddr(m_paddr), .m_pwrite(m_pwrite), .m_pwdata(m_pwdata), .m_pprot(m_pprot),
        .m_pstrb(m_pstrb), .m_penable(m_penable), .m_psel(m_psel),
        .m_pready(m_pready), .m_pslverr(m_pslverr), .m_prdata(m_prdata)
    );

    apb_splitter #(.SLV_MASK(OVL_MASK)) dut2 (
        .clk(clk), .rst(rst),
        .s_paddr(s_paddr), .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
        .s_pwdata(s_pwdata), .s_pprot(s_pprot), .s_pstrb(s_pstrb),
        .s_pready(s2_pready), .s_prdata(s2_prdata), .s_pslverr(s2_pslverr),
        .m_paddr(m2_paddr), .m_pwrite(m2_pwrite), .m_pwdata(m2_pwdata), .m_pprot(m2_pprot),
        .m_pstrb(m2_pstrb), .m_penable(m2_penable), .m_psel(m2_psel),
        .m_pready(4'hF), .m_pslverr(4'h0), .m_prdata('0)
    );

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        int            cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   chk_ovl = 1'b0;

    // slave model configuration
    int          slv_wait [N];
    bit          slv_never[N];
    bit          slv_err  [N];
    logic [31:0] slv_rdata[N];
    int          wcnt     [N];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Downstream slaves: ready after slv_wait access cycles unless told never
    initial begin
        m_pready  = '0;
        m_pslverr = '0;
        m_prdata  = '0;
        for (int i = 0; i < N; i++) wcnt[i] = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                m_prdata[i*DW +: DW] = slv_rdata[i];
                m_pslverr[i]         = slv_err[i];
                if (m_psel[i] && m_penable) begin
                    if (!slv_never[i] && wcnt[i] >= slv_wait[i]) begin
                        m_pready[i] = 1'b1;
                    end else begin
                        m_pready[i] = 1'b0;
                        wcnt[i]++;
                    end
                end else begin
                    m_pready[i] = 1'b0;
                    wcnt[i]     = 0;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on each response, watches invariants
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("psel_onehot", 64'($countones(m_psel) <= 1), 64'(1));
                if (s_pready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_pready", 64'(s_pready), 64'(0));
                    end else begin
                        e = sb.pop_front();
                        chk("resp_prdata", 64'(s_prdata), 64'(e.rdata));
                        chk("resp_pslverr", 64'(s_pslverr), 64'(e.err));
                        chk("resp_cycle", 64'(cyc), 64'(e.cyc));
                    end
                end else begin
                    chk("prdata_idle_zero", 64'(s_prdata), 64'(0));
                end
            end
        end
    end

    task automatic apb_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                            input logic [31:0] exp_rdata, input logic exp_err, input int lat,
                            input logic [N-1:0] exp_sel);
        int   c0;
        bit   done;
        exp_t e;
        c0      = cyc;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.cyc   = c0 + lat;
        sb.push_back(e);
        s_paddr   = addr;
        s_pwrite  = wr;
        s_pwdata  = wdata;
        s_pstrb   = wr ? 4'hF : 4'h0;
        s_pprot   = 3'b010;
        s_psel    = 1'b1;
        s_penable = 1'b0;
        @(posedge clk); #1;
        s_penable = 1'b1;
        done = 1'b0;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            if (cyc == c0 + 1) begin
                chk("setup_psel", 64'(m_psel), 64'(exp_sel));
                chk("setup_penable", 64'(m_penable), 64'(0));
                if (exp_sel != '0) begin
                    chk("setup_paddr", 64'(m_paddr), 64'(addr));
                    chk("setup_pwdata", 64'(m_pwdata), 64'(wdata));
                    chk("setup_pwrite", 64'(m_pwrite), 64'(wr));
                    chk("setup_pstrb", 64'(m_pstrb), wr ? 64'hF : 64'h0);
                    chk("setup_pprot", 64'(m_pprot), 64'h2);
                end
                if (chk_ovl) chk("ovl_psel", 64'(m2_psel), 64'b0001);
            end
            if (cyc == c0 + 2 && exp_sel != '0 && !s_pready) begin
                chk("access_psel", 64'(m_psel), 64'(exp_sel));
                chk("access_penable", 64'(m_penable), 64'(1));
            end
            if (s_pready) begin
                done = 1'b1;
                chk("resp_sel_dropped", 64'({m_penable, m_psel}), 64'(0));
            end
        end
        chk("pready_seen", 64'(done), 64'(1));
        @(posedge clk); #1;
        s_psel    = 1'b0;
        s_penable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int pcnt;
        s_paddr = '0; s_psel = 0; s_penable = 0; s_pwrite = 0;
        s_pwdata = '0; s_pprot = '0; s_pstrb = '0;
        for (int i = 0; i < N; i++) begin
            slv_wait[i] = 0; slv_never[i] = 0; slv_err[i] = 0; slv_rdata[i] = '0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_resp", 64'({s_pready, s_pslverr, m_penable}), 64'(0));
        chk("rst_prdata", 64'(s_prdata), 64'(0));
        chk("rst_psel", 64'(m_psel), 64'(0));
        chk("rst_req", 64'({m_paddr, m_pwrite, m_pprot, m_pstrb}), 64'(0));
        chk("rst_pwdata", 64'(m_pwdata), 64'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        slv_rdata[0] = 32'hA5A5_0001; slv_wait[0] = 1; slv_err[0] = 1;
        slv_rdata[1] = 32'hCAFE_F00D;
        slv_rdata[2] = 32'h55AA_55AA; slv_never[2] = 1;
        slv_rdata[3] = 32'h1234_5678; slv_wait[3] = 3;

        // write to slave1, zero wait; write returns zero data
        apb_xfer(32'h0000_1004, 1'b1, 32'hDEAD_BEEF, 32'h0, 1'b0, 3, 4'b0010);
        // read slave3 after three wait cycles
        apb_xfer(32'h0000_3010, 1'b0, 32'h0, 32'h1234_5678, 1'b0, 6, 4'b1000);
        // unmapped address
        apb_xfer(32'h0001_0000, 1'b0, 32'h0, 32'h0, 1'b1, 1, 4'b0000);
        // slave0 error response after one wait cycle
        apb_xfer(32'h0000_0008, 1'b0, 32'h0, 32'hA5A5_0001, 1'b1, 4, 4'b0001);
        // slave2 never ready: timeout after 16 access cycles
        apb_xfer(32'h0000_2000, 1'b0, 32'h0, 32'h0, 1'b1, 18, 4'b0100);
        // overlap: default instance picks slot1, overlap instance picks slot0
        chk_ovl = 1'b1;
        apb_xfer(32'h0000_1000, 1'b0, 32'h0, 32'hCAFE_F00D, 1'b0, 3, 4'b0010);
        chk_ovl = 1'b0;

        // reset in the middle of an ACCESS phase to slave2
        s_paddr = 32'h0000_2000; s_pwrite = 1'b0; s_pstrb = '0;
        s_psel = 1'b1; s_penable = 1'b0;
        @(posedge clk); #1;
        s_penable = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("pre_rst_penable", 64'(m_penable), 64'(1));
        #2 rst = 1'b1;
        #1;
        chk("rst_abort_sel", 64'({m_penable, m_psel}), 64'(0));
        chk("rst_abort_pready", 64'(s_pready), 64'(0));
        s_psel = 1'b0; s_penable = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        pcnt = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (s_pready) pcnt++;
        end
        chk("no_pready_after_rst", 64'(pcnt), 64'(0));
        @(posedge clk); #1;

        // normal transfer after the aborted one
        slv_wait[3] = 0; slv_rdata[3] = 32'h600D_F00D;
        apb_xfer(32'h0000_3000, 1'b0, 32'h0, 32'h600D_F00D, 1'b0, 3, 4'b1000);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(sb.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop if something wedges the stimulus
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
